// File: rtl/fault_injector_if.sv
// Write-path and configuration-port bundle for the fault injection stage.
// The write path carries no backpressure: in_we/out_we are plain level
// qualifiers, and addr/dat are meaningful only on cycles where the matching
// we is high. The configuration port is a single-cycle strobe (cfg_we) with
// read data returned one cycle after cfg_addr is presented.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

interface fault_injector_if #(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) ();
    logic                      in_we;
    logic [REG_ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0]     in_dat;
    logic                      out_we;
    logic [REG_ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0]     out_dat;
    logic                      cfg_we;
    logic [2:0]                cfg_addr;
    logic [31:0]               cfg_wdata;
    logic [31:0]               cfg_rdata;
    logic                      fi_active;

    // Upstream side: soc_control write path plus the PS configuration port.
    modport master (
        output in_we, in_addr, in_dat, cfg_we, cfg_addr, cfg_wdata,
        input  out_we, out_addr, out_dat, cfg_rdata, fi_active
    );

    // Injector side.
    modport slave (
        input  in_we, in_addr, in_dat, cfg_we, cfg_addr, cfg_wdata,
        output out_we, out_addr, out_dat, cfg_rdata, fi_active
    );
endinterface

// File: rtl/fault_injector.sv
// Inline fault injection stage between soc_control and the register-file
// write port. The write path is registered one cycle; when armed, a selected
// write event has its data corrupted by a mask (flip / stuck-0 / stuck-1)
// for the whole we-high window of that event.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module fault_injector #(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    fault_injector_if.slave   bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_INJECT = 2'b10
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'b11;

    state_t                    state_q, state_d;
    logic                      we_d_q, we_d_d;
    logic [1:0]                mode_q, mode_d;
    logic [4:0]                target_q, target_d;
    logic                      any_q, any_d;
    logic                      repeat_q, repeat_d;
    logic [31:0]               mask_q, mask_d;
    logic [7:0]                skip_q, skip_d;
    logic [7:0]                skip_cnt_q, skip_cnt_d;
    logic [7:0]                count_q, count_d;
    logic [1:0]                sh_mode_q, sh_mode_d;
    logic [DATA_WIDTH-1:0]     sh_mask_q, sh_mask_d;
    logic [DATA_WIDTH-1:0]     orig_q, orig_d;
    logic                      out_we_q, out_we_d;
    logic [REG_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]     out_dat_q, out_dat_d;
    logic                      fi_active_q, fi_active_d;
    logic [31:0]               cfg_rdata_q, cfg_rdata_d;

    logic                      wr_event;
    logic                      hit;
    logic                      ctrl_wr;
    logic                      fire_arm;
    logic                      fire_now;
    logic [1:0]                eff_mode;
    logic [DATA_WIDTH-1:0]     eff_mask;

    function automatic logic [DATA_WIDTH-1:0] corrupt(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] k
    );
        case (m)
            2'b00:   return d ^ k;
            2'b01:   return d & ~k;
            2'b10:   return d | k;
            default: return d;
        endcase
    endfunction

    // Next-state logic: event detection, injection FSM, config bank and read mux.
    always_comb begin
        state_d     = state_q;
        we_d_d      = bus.in_we;
        mode_d      = mode_q;
        target_d    = target_q;
        any_d       = any_q;
        repeat_d    = repeat_q;
        mask_d      = mask_q;
        skip_d      = skip_q;
        skip_cnt_d  = skip_cnt_q;
        count_d     = count_q;
        sh_mode_d   = sh_mode_q;
        sh_mask_d   = sh_mask_q;
        orig_d      = orig_q;
        cfg_rdata_d = 32'd0;

        // A write event is the rising edge of in_we; a CTRL write in the same
        // cycle wins and the event is not counted.
        wr_event = bus.in_we & ~we_d_q;
        hit      = wr_event & (any_q | (bus.in_addr == REG_ADDR_WIDTH'(target_q)));
        ctrl_wr  = bus.cfg_we & (bus.cfg_addr == 3'd0);
        fire_arm = (state_q == ST_ARMED) & hit & (skip_cnt_q == 8'd0) & ~ctrl_wr;
        fire_now = fire_arm | ((state_q == ST_INJECT) & bus.in_we);

        // The first cycle of a window uses live CTRL/MASK; later cycles use
        // the shadow copy so mid-window config writes do not disturb it.
        eff_mode = (state_q == ST_INJECT) ? sh_mode_q : mode_q;
        eff_mask = (state_q == ST_INJECT) ? sh_mask_q : DATA_WIDTH'(mask_q);

        out_we_d    = bus.in_we;
        out_addr_d  = bus.in_addr;
        out_dat_d   = fire_now ? corrupt(bus.in_dat, eff_mode, eff_mask) : bus.in_dat;
        fi_active_d = fire_now & (eff_mode != MODE_PASS);

        case (state_q)
            ST_ARMED: begin
                if (hit && !ctrl_wr) begin
                    if (skip_cnt_q == 8'd0) begin
                        state_d   = ST_INJECT;
                        sh_mode_d = mode_q;
                        sh_mask_d = DATA_WIDTH'(mask_q);
                        orig_d    = bus.in_dat;
                        count_d   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    end else begin
                        skip_cnt_d = skip_cnt_q - 8'd1;
                    end
                end
            end
            ST_INJECT: begin
                if (!bus.in_we) begin
                    state_d    = repeat_q ? ST_ARMED : ST_IDLE;
                    skip_cnt_d = skip_q;
                end
            end
            default: ;
        endcase

        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                3'd0: begin
                    mode_d   = bus.cfg_wdata[1:0];
                    target_d = bus.cfg_wdata[6:2];
                    any_d    = bus.cfg_wdata[7];
                    repeat_d = bus.cfg_wdata[9];
                    if (!bus.cfg_wdata[8]) begin
                        state_d = ST_IDLE;
                    end else if (state_q != ST_INJECT) begin
                        state_d    = ST_ARMED;
                        skip_cnt_d = skip_q;
                    end
                end
                3'd1:    mask_d  = bus.cfg_wdata;
                3'd2:    skip_d  = bus.cfg_wdata[7:0];
                3'd3:    count_d = 8'd0;
                default: ;
            endcase
        end

        case (bus.cfg_addr)
            3'd0:    cfg_rdata_d = {22'd0, repeat_q, (state_q != ST_IDLE), any_q, target_q, mode_q};
            3'd1:    cfg_rdata_d = mask_q;
            3'd2:    cfg_rdata_d = {24'd0, skip_q};
            3'd3:    cfg_rdata_d = {22'd0, state_q, count_q};
            3'd4:    cfg_rdata_d = 32'(orig_q);
            default: cfg_rdata_d = 32'd0;
        endcase
    end

    // State register for the FSM, config bank and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_d_q      <= 1'b0;
            mode_q      <= 2'd0;
            target_q    <= 5'd0;
            any_q       <= 1'b0;
            repeat_q    <= 1'b0;
            mask_q      <= 32'd0;
            skip_q      <= 8'd0;
            skip_cnt_q  <= 8'd0;
            count_q     <= 8'd0;
            sh_mode_q   <= 2'd0;
            sh_mask_q   <= '0;
            orig_q      <= '0;
            out_we_q    <= 1'b0;
            out_addr_q  <= '0;
            out_dat_q   <= '0;
            fi_active_q <= 1'b0;
            cfg_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_d_q      <= we_d_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            any_q       <= any_d;
            repeat_q    <= repeat_d;
            mask_q      <= mask_d;
            skip_q      <= skip_d;
            skip_cnt_q  <= skip_cnt_d;
            count_q     <= count_d;
            sh_mode_q   <= sh_mode_d;
            sh_mask_q   <= sh_mask_d;
            orig_q      <= orig_d;
            out_we_q    <= out_we_d;
            out_addr_q  <= out_addr_d;
            out_dat_q   <= out_dat_d;
            fi_active_q <= fi_active_d;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    assign bus.out_we    = out_we_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_dat   = out_dat_q;
    assign bus.fi_active = fi_active_q;
    assign bus.cfg_rdata = cfg_rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fault_injector.sv
// Bench for fault_injector: directed scenarios followed by random traffic,
// every cycle checked against a transaction-level model of the injector.

`timescale 1ns/1ps

module tb_fault_injector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    fault_injector_if bus ();

    fault_injector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: configuration plus "armed" / "in a fault window" flags.
    logic [1:0]  m_mode;
    logic [4:0]  m_target;
    logic        m_any, m_rep;
    logic [31:0] m_mask;
    logic [7:0]  m_skip;
    logic        m_armed, m_window, m_prev_we;
    int          m_left, m_count;
    logic [31:0] m_orig, m_sh_mask;
    logic [1:0]  m_sh_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] apply_fault(input logic [31:0] d, input logic [1:0] m, input logic [31:0] k);
        if (m == 2'd0) return d ^ k;
        if (m == 2'd1) return d & ~k;
        if (m == 2'd2) return d | k;
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        int code;
        code = m_window ? 2 : (m_armed ? 1 : 0);
        case (a)
            3'd0:    return (32'(m_rep) << 9) | (32'(m_armed) << 8) | (32'(m_any) << 7) |
                            (32'(m_target) << 2) | 32'(m_mode);
            3'd1:    return m_mask;
            3'd2:    return 32'(m_skip);
            3'd3:    return 32'(m_count) + 32'(code * 256);
            3'd4:    return m_orig;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_target = 0; m_any = 0; m_rep = 0; m_mask = 0; m_skip = 0;
        m_armed = 0; m_window = 0; m_prev_we = 0; m_left = 0; m_count = 0;
        m_orig = 0; m_sh_mask = 0; m_sh_mode = 0;
    endtask

    // One clock cycle: drive at negedge, predict, check 1 ns after posedge.
    task automatic cyc(input logic we, input logic [4:0] addr, input logic [31:0] dat,
                       input logic cwe, input logic [2:0] ca, input logic [31:0] cwd);
        logic        is_ev, hits, ctrl_w, n_armed, n_window, e_act;
        logic [31:0] e_dat, e_rd;
        int          n_left;
        bus.in_we = we; bus.in_addr = addr; bus.in_dat = dat;
        bus.cfg_we = cwe; bus.cfg_addr = ca; bus.cfg_wdata = cwd;
        e_rd   = model_read(ca);
        e_dat  = dat;
        e_act  = 1'b0;
        is_ev  = we && !m_prev_we;
        hits   = is_ev && (m_any || addr == m_target);
        ctrl_w = cwe && ca == 3'd0;
        n_armed = m_armed; n_window = m_window; n_left = m_left;
        if (m_window) begin
            if (we) begin
                e_dat = apply_fault(dat, m_sh_mode, m_sh_mask);
                e_act = (m_sh_mode != 2'd3);
            end else begin
                n_window = 0; n_armed = m_rep; n_left = m_skip;
            end
        end else if (m_armed && hits && !ctrl_w) begin
            if (m_left == 0) begin
                e_dat = apply_fault(dat, m_mode, m_mask);
                e_act = (m_mode != 2'd3);
                m_sh_mode = m_mode; m_sh_mask = m_mask; m_orig = dat;
                if (m_count < 255) m_count++;
                n_window = 1;
            end else begin
                n_left = m_left - 1;
            end
        end
        if (ctrl_w) begin
            if (!cwd[8]) begin
                n_armed = 0; n_window = 0;
            end else if (!m_window) begin
                n_armed = 1; n_left = m_skip;
            end
        end
        if (cwe) begin
            case (ca)
                3'd0: begin m_mode = cwd[1:0]; m_target = cwd[6:2]; m_any = cwd[7]; m_rep = cwd[9]; end
                3'd1: m_mask = cwd;
                3'd2: m_skip = cwd[7:0];
                3'd3: m_count = 0;
                default: ;
            endcase
        end
        m_armed = n_armed; m_window = n_window; m_left = n_left; m_prev_we = we;
        @(posedge clk); #1;
        check("out_we", 32'(bus.out_we), 32'(we));
        check("out_addr", 32'(bus.out_addr), 32'(addr));
        check("out_dat", bus.out_dat, e_dat);
        check("fi_active", 32'(bus.fi_active), 32'(e_act));
        check("cfg_rdata", bus.cfg_rdata, e_rd);
        check("state", 32'(dbg_state), 32'(m_window ? 2 : (m_armed ? 1 : 0)));
        @(negedge clk);
    endtask

    task automatic do_reset(input logic we, input logic [4:0] addr, input logic [31:0] dat);
        rst_n = 1'b0;
        bus.in_we = we; bus.in_addr = addr; bus.in_dat = dat;
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 32'd0;
        @(posedge clk); #1;
        check("rst_out_we", 32'(bus.out_we), 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_out_dat", bus.out_dat, 32'd0);
        check("rst_fi_active", 32'(bus.fi_active), 32'd0);
        check("rst_cfg_rdata", bus.cfg_rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, a, 32'd0);
    endtask

    initial begin
        logic [4:0]  sk_addr [4];
        logic        r_we;
        logic [2:0]  r_ca;
        logic [31:0] r_cwd;

        sk_addr = '{5'd3, 5'd7, 5'd3, 5'd3};
        model_reset();
        @(negedge clk);
        do_reset(1'b0, 5'd0, 32'd0);

        // Pass-through while idle.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'd3, 32'd0);
            check("pt_dat", bus.out_dat, 32'hDEADBEEF);
            check("pt_active", 32'(bus.fi_active), 32'd0);
        end
        rd(3'd3);
        check("pt_status", bus.cfg_rdata, 32'd0);

        // Flip bit 0 of a 3-cycle write to x5.
        cfg(3'd1, 32'h1);
        cfg(3'd0, (32'd5 << 2) | (32'd1 << 8));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'd5, 32'h10, 1'b0, 3'd0, 32'd0);
            check("flip_dat", bus.out_dat, 32'h11);
            check("flip_active", 32'(bus.fi_active), 32'd1);
        end
        rd(3'd4);
        check("flip_orig", bus.cfg_rdata, 32'h10);
        rd(3'd3);
        check("flip_status", bus.cfg_rdata, 32'h001);

        // Skip two matching events, stuck-1 on the third.
        cfg(3'd2, 32'd2);
        cfg(3'd1, 32'hF0);
        cfg(3'd0, (32'd3 << 2) | 32'd2 | (32'd1 << 8));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, sk_addr[i], 32'd0, 1'b0, 3'd0, 32'd0);
            check("skip_dat", bus.out_dat, (i == 3) ? 32'hF0 : 32'h0);
            cyc(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
        end

        // Repeat with any_reg, stuck-0 full mask; count saturates.
        cfg(3'd2, 32'd0);
        cfg(3'd1, 32'hFFFFFFFF);
        cfg(3'd0, (32'd1 << 9) | (32'd1 << 8) | (32'd1 << 7) | 32'd1);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 5'($urandom_range(0, 31)), 32'hFF, 1'b0, 3'd3, 32'd0);
            check("rep_dat", bus.out_dat, 32'd0);
            cyc(1'b0, 5'd0, 32'd0, 1'b0, 3'd3, 32'd0);
        end
        rd(3'd3);
        check("rep_sat", bus.cfg_rdata, 32'h1FF);
        cfg(3'd3, 32'd0);
        rd(3'd3);
        check("rep_clear", bus.cfg_rdata, 32'h100);
        cfg(3'd0, 32'd0);

        // Disarm in the middle of a 5-cycle window.
        cfg(3'd1, 32'hFF);
        cfg(3'd0, (32'd5 << 2) | (32'd1 << 8));
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 5'd5, 32'hA5, (k == 2), 3'd0, 32'd0);
            check("disarm_dat", bus.out_dat, (k >= 3) ? 32'hA5 : 32'h5A);
        end
        rd(3'd3);
        check("disarm_state", 32'(bus.cfg_rdata[9:8]), 32'd0);

        // Reset in the middle of a window.
        cfg(3'd0, (32'd5 << 2) | (32'd1 << 8));
        cyc(1'b1, 5'd5, 32'hA5, 1'b0, 3'd0, 32'd0);
        cyc(1'b1, 5'd5, 32'hA5, 1'b0, 3'd0, 32'd0);
        do_reset(1'b1, 5'd5, 32'hA5);
        cyc(1'b1, 5'd5, 32'hA5, 1'b0, 3'd0, 32'd0);
        check("post_rst_dat", bus.out_dat, 32'hA5);
        rd(3'd0);

        // Arm in the same cycle as a matching event: that write is untouched.
        cfg(3'd1, 32'hFF);
        cyc(1'b1, 5'd5, 32'h33, 1'b1, 3'd0, (32'd5 << 2) | (32'd1 << 8));
        check("coll_dat", bus.out_dat, 32'h33);
        cyc(1'b1, 5'd5, 32'h33, 1'b0, 3'd0, 32'd0);
        check("coll_hold", bus.out_dat, 32'h33);
        rd(3'd0);
        check("coll_armed", bus.cfg_rdata, (32'd5 << 2) | (32'd1 << 8));
        cfg(3'd0, 32'd0);

        // Reserved mode: passes data but still counts.
        cfg(3'd3, 32'd0);
        cfg(3'd0, (32'd5 << 2) | 32'd3 | (32'd1 << 8));
        cyc(1'b1, 5'd5, 32'h12, 1'b0, 3'd0, 32'd0);
        check("m11_dat", bus.out_dat, 32'h12);
        check("m11_active", 32'(bus.fi_active), 32'd0);
        rd(3'd3);
        check("m11_count", 32'(bus.cfg_rdata[7:0]), 32'd1);

        // Random traffic against the model.
        r_we = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r_we = ~r_we;
            r_ca = 3'($urandom_range(0, 7));
            if (r_ca == 3'd2)
                r_cwd = 32'($urandom_range(0, 3));
            else if (r_ca == 3'd0)
                r_cwd = 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 7)) << 2) |
                        (32'($urandom_range(0, 1)) << 7) | (32'($urandom_range(0, 3) != 0) << 8) |
                        (32'($urandom_range(0, 1)) << 9);
            else
                r_cwd = $urandom;
            if ($urandom_range(0, 299) == 0)
                do_reset(r_we, 5'($urandom_range(0, 7)), $urandom);
            else
                cyc(r_we, 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 7) == 0), r_ca, r_cwd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
